// File: rtl/mult_req_sequencer_if.sv
// ---------------------------------------------------------------------------
// mult_req_sequencer_if
// Request/result bus between the operand sequencer and the 16x16 signed
// multiplier core.
//   master (sequencer): drives arg_a/arg_b with their parities and req;
//                       receives ack, result, result_parity, result_rdy
//                       and arg_parity_error.
//   slave  (core)     : the mirror image.
// ---------------------------------------------------------------------------
interface mult_req_sequencer_if;
    logic [15:0] arg_a;
    logic        arg_a_parity;
    logic [15:0] arg_b;
    logic        arg_b_parity;
    logic        req;
    logic        ack;
    logic [31:0] result;
    logic        result_parity;
    logic        result_rdy;
    logic        arg_parity_error;

    modport master (
        output arg_a, arg_a_parity, arg_b, arg_b_parity, req,
        input  ack, result, result_parity, result_rdy, arg_parity_error
    );

    modport slave (
        input  arg_a, arg_a_parity, arg_b, arg_b_parity, req,
        output ack, result, result_parity, result_rdy, arg_parity_error
    );
endinterface

// File: rtl/mult_req_sequencer.sv
// ---------------------------------------------------------------------------
// mult_req_sequencer
// Operand issue stage in front of the multiplier core. Operand pairs are
// queued in a small FIFO, tagged with (optionally corrupted) parity, issued
// one at a time over the core's req/ack handshake, and every operation
// produces exactly one result record on the downstream stream (a real
// result, or a zero result flagged as a timeout).
//
// Ports
//   clk, rst          : single clock; synchronous active-high reset
//   in_valid/in_ready : operand stream handshake (in_ready = !full, 0 in rst)
//   in_a, in_b        : signed operands
//   in_corrupt        : bit0/bit1 invert the stored parity of A/B
//   core              : master side of the core request/result bus
//   out_valid/ready   : result record handshake
//   out_result        : captured core result, 0 on timeout
//   out_arg_err       : core reported an argument parity error
//   out_res_err       : result parity did not match the result data
//   out_timeout       : operation aborted waiting for ack or result_rdy
//   fifo_count        : operand FIFO occupancy
// ---------------------------------------------------------------------------
module mult_req_sequencer #(
    parameter int DEPTH   = 4,    // power of two, 2..16
    parameter int TIMEOUT = 255   // cycles allowed in REQ and in WAIT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             in_a,
    input  logic [15:0]             in_b,
    input  logic [1:0]              in_corrupt,
    mult_req_sequencer_if.master    core,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic                    out_arg_err,
    output logic                    out_res_err,
    output logic                    out_timeout,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    // The timer starts at 0 on entry, so hitting TIMEOUT-1 at an edge means
    // that edge closes the TIMEOUT-th cycle spent in the state.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [15:0] a;
        logic        pa;
        logic [15:0] b;
        logic        pb;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        OUT
    } state_t;

    entry_t             mem [DEPTH];
    entry_t             args;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic               fifo_empty;

    state_t             state;
    state_t             state_n;
    logic [TMR_W-1:0]   timer;
    logic               timer_done;
    logic               capture;
    logic               abort;

    // in_ready looks only at the registered count, so a full FIFO refuses a
    // push even in a cycle where the FSM pops the head.
    assign in_ready   = !rst && (fifo_count != CNT_FULL);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (fifo_count == '0);

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and clearing the pointers/count empties the FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a:  in_a, pa: (^in_a) ^ in_corrupt[0],
                             b:  in_b, pb: (^in_b) ^ in_corrupt[1]};
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            // Pointers are PTR_W bits wide, so they wrap modulo DEPTH.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and per-cycle strobes
    // ------------------------------------------------------------------
    assign timer_done = (timer == TMR_LAST);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                // A late ack/result_rdy from an aborted op is ignored here.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (core.ack && core.result_rdy) begin
                    // ack and result in one cycle: skip WAIT entirely.
                    capture = 1'b1;
                    state_n = OUT;
                end else if (core.ack) begin
                    state_n = WAIT;
                end else if (timer_done) begin
                    abort   = 1'b1;
                    state_n = OUT;
                end
            end
            WAIT: begin
                if (core.result_rdy) begin
                    capture = 1'b1;
                    state_n = OUT;
                end else if (timer_done) begin
                    abort   = 1'b1;
                    state_n = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            args        <= '0;
            out_result  <= '0;
            out_arg_err <= 1'b0;
            out_res_err <= 1'b0;
            out_timeout <= 1'b0;
        end else begin
            state <= state_n;

            // Restart the timer on every state change; it only runs while
            // waiting on the core.
            if (state_n != state) begin
                timer <= '0;
            end else if (state == REQ || state == WAIT) begin
                timer <= timer + TMR_W'(1);
            end

            // Args are loaded once on issue and held until the next issue.
            if (pop) args <= mem[rd_ptr];

            if (capture) begin
                out_result  <= core.result;
                out_arg_err <= core.arg_parity_error;
                out_res_err <= core.result_parity != (^core.result);
                out_timeout <= 1'b0;
            end else if (abort) begin
                out_result  <= '0;
                out_arg_err <= 1'b0;
                out_res_err <= 1'b0;
                out_timeout <= 1'b1;
            end
        end
    end

    assign out_valid         = (state == OUT);
    assign core.req          = (state == REQ);
    assign core.arg_a        = args.a;
    assign core.arg_a_parity = args.pa;
    assign core.arg_b        = args.b;
    assign core.arg_b_parity = args.pb;

endmodule
